auto_door_ctrl_n: RTL and testbench

AUTO_DOOR_CTRL_N -- requirements
Module: auto_door_ctrl_n

---
 rtl/auto_door_ctrl_n.sv | 177 +++++++++++++++++
 tb/tb_auto_door_ctrl_n.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_door_ctrl_n.sv
// Automatic sliding-door controller driving N_LEAF leaves in lock-step, with lock bolt and tamper alarm.
// Optional macro DOOR_TRAVEL_TIMEOUT_EN adds a travel watchdog and a sticky FAULT state.
module auto_door_ctrl_n #(
  parameter int N_LEAF      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int ALARM_TRIES = 3,
  parameter int TRAVEL_MAX  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pa,
  input  logic              pp,
  input  logic              mo,
  input  logic              lk,
  input  logic              alarm_clr,
  input  logic [N_LEAF-1:0] lim_open,
  input  logic [N_LEAF-1:0] lim_closed,
  output logic [N_LEAF-1:0] motor_open,
  output logic [N_LEAF-1:0] motor_close,
  output logic              bolt,
  output logic              alarm,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int CW = $clog2(ALARM_TRIES + 1);

  localparam logic [2:0] S_CLOSED  = 3'b000;
  localparam logic [2:0] S_OPENING = 3'b001;
  localparam logic [2:0] S_OPEN    = 3'b011;
  localparam logic [2:0] S_CLOSING = 3'b010;
  localparam logic [2:0] S_LOCKED  = 3'b100;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
  localparam logic [2:0] S_FAULT   = 3'b101;
`endif

  logic [2:0]    state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          alarm_q, alarm_d;
  logic          mo_q;
  logic          demand, all_open, all_closed;
  logic          attempt, leave_locked;

  assign demand       = pa | pp | mo;
  assign all_open     = &lim_open;
  assign all_closed   = &lim_closed;
  assign attempt      = (state_q == S_LOCKED) & mo & ~mo_q;
  assign leave_locked = (state_q == S_LOCKED) & ~lk;

`ifdef DOOR_TRAVEL_TIMEOUT_EN
  logic [15:0] trav_q, trav_d;
  logic        trav_expired;
  assign trav_expired = (trav_q == 16'(TRAVEL_MAX - 1));
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
    trav_d  = trav_q;
`endif
    case (state_q)
      S_CLOSED: begin
        if (lk) begin
          state_d = S_LOCKED;
        end else if (demand) begin
          state_d = S_OPENING;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
          trav_d  = '0;
`endif
        end
      end
      S_LOCKED: begin
        if (!lk) state_d = S_CLOSED;
      end
      S_OPENING: begin
        // A limit met in the same cycle as the watchdog expiry wins.
        if (all_open) begin
          state_d = S_OPEN;
          hold_d  = 16'(HOLD_CYCLES - 1);
        end
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        else if (trav_expired) state_d = S_FAULT;
        else trav_d = trav_q + 16'd1;
`endif
      end
      S_OPEN: begin
        if (demand) begin
          hold_d = 16'(HOLD_CYCLES - 1);
        end else if (hold_q == 16'd0) begin
          state_d = S_CLOSING;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
          trav_d  = '0;
`endif
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_CLOSING: begin
        // Re-open on demand takes priority over reaching the closed stops.
        if (demand) begin
          state_d = S_OPENING;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
          trav_d  = '0;
`endif
        end else if (all_closed) begin
          state_d = S_CLOSED;
        end
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        else if (trav_expired) state_d = S_FAULT;
        else trav_d = trav_q + 16'd1;
`endif
      end
`ifdef DOOR_TRAVEL_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_CLOSED;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (alarm_clr) begin
      cnt_d   = '0;
      alarm_d = 1'b0;
    end else begin
      if (leave_locked && !alarm_q) begin
        cnt_d = '0;
      end else if (attempt && (cnt_q != CW'(ALARM_TRIES))) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(ALARM_TRIES)) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLOSED;
      hold_q  <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      mo_q    <= 1'b0;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
      trav_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      mo_q    <= mo;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
      trav_q  <= trav_d;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LEAF; gi++) begin : g_leaf
      assign motor_open[gi]  = (state_q == S_OPENING) & ~lim_open[gi];
      assign motor_close[gi] = (state_q == S_CLOSING) & ~lim_closed[gi];
    end
  endgenerate

  assign bolt  = (state_q == S_LOCKED);
  assign alarm = alarm_q;
  assign state = state_q;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_auto_door_ctrl_n.sv
// Bench for auto_door_ctrl_n: vector table, hand sequences for timing corners, and random run vs. a reference model.
module tb_auto_door_ctrl_n;

  localparam int HOLD      = 16;
  localparam int TRIES     = 3;
  localparam int TB_TRAVEL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pa, pp, mo, lk, alarm_clr;
  logic [1:0] lim_open, lim_closed, motor_open, motor_close;
  logic       bolt, alarm, fault;
  logic [2:0] state;

  logic [2:0] lim_open3, lim_closed3, motor_open3, motor_close3;
  logic       bolt3, alarm3, fault3;
  logic [2:0] state3;

  auto_door_ctrl_n #(.N_LEAF(2), .HOLD_CYCLES(HOLD), .ALARM_TRIES(TRIES), .TRAVEL_MAX(TB_TRAVEL)) dut (
    .clk(clk), .reset(reset), .pa(pa), .pp(pp), .mo(mo), .lk(lk), .alarm_clr(alarm_clr),
    .lim_open(lim_open), .lim_closed(lim_closed), .motor_open(motor_open), .motor_close(motor_close),
    .bolt(bolt), .alarm(alarm), .fault(fault), .state(state));

  auto_door_ctrl_n #(.N_LEAF(3)) dut3 (
    .clk(clk), .reset(reset), .pa(pa), .pp(pp), .mo(mo), .lk(lk), .alarm_clr(alarm_clr),
    .lim_open(lim_open3), .lim_closed(lim_closed3), .motor_open(motor_open3), .motor_close(motor_close3),
    .bolt(bolt3), .alarm(alarm3), .fault(fault3), .state(state3));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic p, input logic m, input logic l,
                       input logic c, input logic [1:0] lo, input logic [1:0] lc);
    reset = r; pa = a; pp = p; mo = m; lk = l; alarm_clr = c; lim_open = lo; lim_closed = lc;
  endtask

  typedef struct {
    logic       rst, pa, pp, mo, lk, clr;
    logic [1:0] lo, lc;
    logic [2:0] st;
    logic [1:0] mop, mcl;
    logic       bolt, alarm;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  function automatic vec_t mk(input logic r, input logic a, input logic p, input logic m, input logic l,
                              input logic c, input logic [1:0] lo, input logic [1:0] lc, input logic [2:0] st,
                              input logic [1:0] mop, input logic [1:0] mcl, input logic b, input logic al);
    vec_t v;
    v.rst = r; v.pa = a; v.pp = p; v.mo = m; v.lk = l; v.clr = c; v.lo = lo; v.lc = lc;
    v.st = st; v.mop = mop; v.mcl = mcl; v.bolt = b; v.alarm = al;
    return v;
  endfunction

  task automatic run_table(input string tag, input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      drive(t[i].rst, t[i].pa, t[i].pp, t[i].mo, t[i].lk, t[i].clr, t[i].lo, t[i].lc);
      step();
      $display("%s vec %0d: state=%b mopen=%b mclose=%b bolt=%b alarm=%b", tag, i, state, motor_open,
               motor_close, bolt, alarm);
      chk($sformatf("%s[%0d].state", tag, i), 32'(state), 32'(t[i].st));
      chk($sformatf("%s[%0d].motors", tag, i), 32'({motor_open, motor_close}), 32'({t[i].mop, t[i].mcl}));
      chk($sformatf("%s[%0d].bolt_alarm_fault", tag, i), 32'({bolt, alarm, fault}), 32'({t[i].bolt, t[i].alarm, 1'b0}));
    end
  endtask

  // Reference model: door phase plus elapsed-cycle counters.
  typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING, M_LOCKED, M_FAULT} mst_t;
  mst_t m_st;
  int   m_quiet, m_trav, m_cnt;
  logic m_alarm, m_mo_prev;

  function automatic logic [2:0] code_of(input mst_t s);
    case (s)
      M_OPENING: return 3'b001;
      M_OPEN:    return 3'b011;
      M_CLOSING: return 3'b010;
      M_LOCKED:  return 3'b100;
      M_FAULT:   return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  task automatic model_tick();
    logic dem;
    dem = pa | pp | mo;
    if (reset) begin
      m_st = M_CLOSED; m_quiet = 0; m_trav = 0; m_cnt = 0; m_alarm = 1'b0; m_mo_prev = 1'b0;
      return;
    end
    if (alarm_clr) begin
      m_cnt = 0; m_alarm = 1'b0;
    end else begin
      if (m_st == M_LOCKED && mo && !m_mo_prev) m_cnt = (m_cnt + 1 > TRIES) ? TRIES : m_cnt + 1;
      if (m_st == M_LOCKED && !lk && !m_alarm) m_cnt = 0;
      if (m_cnt == TRIES) m_alarm = 1'b1;
    end
    m_mo_prev = mo;
    case (m_st)
      M_CLOSED:  if (lk) m_st = M_LOCKED; else if (dem) begin m_st = M_OPENING; m_trav = 0; end
      M_LOCKED:  if (!lk) m_st = M_CLOSED;
      M_OPENING: begin
        if (&lim_open) begin m_st = M_OPEN; m_quiet = 0; end
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        else begin m_trav++; if (m_trav == TB_TRAVEL) m_st = M_FAULT; end
`endif
      end
      M_OPEN: begin
        if (dem) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == HOLD) begin m_st = M_CLOSING; m_trav = 0; end
        end
      end
      M_CLOSING: begin
        if (dem) begin m_st = M_OPENING; m_trav = 0; end
        else if (&lim_closed) m_st = M_CLOSED;
`ifdef DOOR_TRAVEL_TIMEOUT_EN
        else begin m_trav++; if (m_trav == TB_TRAVEL) m_st = M_FAULT; end
`endif
      end
      default: m_st = M_FAULT;
    endcase
  endtask

  initial begin
    logic [1:0] e_mo, e_mc;
    logic       lk_s;

    // Three-leaf instance: partial open limits drive only the lagging leaf.
    lim_open3 = 3'b000; lim_closed3 = 3'b111;
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b11);
    step();
    chk("n3.reset_state", 32'(state3), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 2'b00, 2'b11);
    step();
    chk("n3.opening", 32'({state3, motor_open3}), 32'({3'b001, 3'b111}));
    pa = 0; lim_open3 = 3'b101;
    step();
    chk("n3.partial_open", 32'({state3, motor_open3, motor_close3}), 32'({3'b001, 3'b010, 3'b000}));

    tab_a.push_back(mk(1,0,0,0,0,0, 2'b00,2'b11, 3'b000,2'b00,2'b00, 0,0));
    tab_a.push_back(mk(0,1,0,0,0,0, 2'b00,2'b11, 3'b001,2'b11,2'b00, 0,0));
    tab_a.push_back(mk(0,0,0,0,0,0, 2'b01,2'b00, 3'b001,2'b10,2'b00, 0,0));
    tab_a.push_back(mk(0,0,0,0,0,0, 2'b11,2'b00, 3'b011,2'b00,2'b00, 0,0));

    tab_b.push_back(mk(0,0,0,0,0,0, 2'b00,2'b01, 3'b010,2'b00,2'b10, 0,0));
    tab_b.push_back(mk(0,0,1,0,0,0, 2'b00,2'b11, 3'b001,2'b11,2'b00, 0,0));
    tab_b.push_back(mk(0,0,0,0,0,0, 2'b11,2'b00, 3'b011,2'b00,2'b00, 0,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b11,2'b00, 3'b011,2'b00,2'b00, 0,0));
    tab_b.push_back(mk(1,1,0,0,1,0, 2'b00,2'b00, 3'b000,2'b00,2'b00, 0,0));
    tab_b.push_back(mk(0,1,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(0,0,0,0,0,0, 2'b00,2'b11, 3'b000,2'b00,2'b00, 0,1));
    tab_b.push_back(mk(0,0,0,0,0,1, 2'b00,2'b11, 3'b000,2'b00,2'b00, 0,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,0,0, 2'b00,2'b11, 3'b000,2'b00,2'b00, 0,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(0,0,0,1,1,1, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,0));
    tab_b.push_back(mk(0,0,0,1,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(0,1,0,0,1,0, 2'b00,2'b11, 3'b100,2'b00,2'b00, 1,1));
    tab_b.push_back(mk(1,0,0,0,0,0, 2'b00,2'b11, 3'b000,2'b00,2'b00, 0,0));

    run_table("open", tab_a);

    // Hold time: close exactly HOLD cycles after the last demand seen while open.
    drive(0, 0, 0, 0, 0, 0, 2'b11, 2'b00);
    for (int i = 0; i < 10; i++) step();
    chk("hold.mid_open", 32'(state), 32'b011);
    pp = 1;
    step();
    pp = 0;
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk($sformatf("hold.still_open_%0d", i), 32'(state), 32'b011);
    end
    step();
    chk("hold.closing", 32'(state), 32'b010);
    lim_open = 2'b00;

    run_table("close_lock", tab_b);

`ifdef DOOR_TRAVEL_TIMEOUT_EN
    drive(1, 0, 0, 0, 0, 0, 2'b00, 2'b11);
    step();
    drive(0, 1, 0, 0, 0, 0, 2'b00, 2'b11);
    step();
    pa = 0;
    for (int i = 1; i < TB_TRAVEL; i++) step();
    chk("timeout.before", 32'({state, fault}), 32'({3'b001, 1'b0}));
    step();
    chk("timeout.fault", 32'({state, fault, bolt, motor_open, motor_close}), 32'({3'b101, 1'b1, 1'b0, 4'b0000}));
    pa = 1; lk = 1;
    for (int i = 0; i < 4; i++) step();
    chk("timeout.sticky", 32'({state, fault}), 32'({3'b101, 1'b1}));
    reset = 1; lk = 0; pa = 0;
    step();
    chk("timeout.reset", 32'({state, fault}), 32'({3'b000, 1'b0}));
`endif

    // Random run against the reference model.
    lk_s = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) lk_s = ~lk_s;
      drive((cyc == 0) || ($urandom_range(0, 149) == 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
            lk_s, $urandom_range(0, 39) == 0, 2'($urandom), 2'($urandom));
      model_tick();
      step();
      for (int i = 0; i < 2; i++) begin
        e_mo[i] = (m_st == M_OPENING) && !lim_open[i];
        e_mc[i] = (m_st == M_CLOSING) && !lim_closed[i];
      end
      chk($sformatf("rand[%0d] {state,mo,mc,bolt,alarm,fault}", cyc),
          32'({state, motor_open, motor_close, bolt, alarm, fault}),
          32'({code_of(m_st), e_mo, e_mc, (m_st == M_LOCKED), m_alarm, (m_st == M_FAULT)}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
